signed_bcd_converter: RTL and testbench

//   Sequential converter from a two's-complement ALU result to sign-magnitude BCD for the

---
 rtl/signed_bcd_converter_if.sv | 30 +++
 rtl/signed_bcd_converter.sv | 99 +++++++++
 tb/tb_signed_bcd_converter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/signed_bcd_converter_if.sv
// Handshake and result bundle between an ALU-side requester and the signed BCD converter.
interface signed_bcd_converter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) ();
  logic                  start;
  logic [WIDTH-1:0]      din;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start,
    output din,
    input  busy,
    input  done,
    input  neg,
    input  bcd
  );

  modport slave (
    input  start,
    input  din,
    output busy,
    output done,
    output neg,
    output bcd
  );
endinterface

// File: rtl/signed_bcd_converter.sv
// Two's-complement to sign-magnitude BCD converter using double dabble, one bit per clock.
// Results are held in neg/bcd until the next conversion completes.
module signed_bcd_converter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  signed_bcd_converter_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [4*DIGITS-1:0]   adjusted;
  logic [CntW-1:0]       count_q, count_d;
  logic                  done_q, done_d;
  logic                  neg_q, neg_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    done_d    = 1'b0;
    neg_d     = neg_q;
    bcd_d     = bcd_q;

    // Pre-shift correction: a digit >= 5 would exceed 9 once doubled.
    adjusted = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sign_d    = bus.din[WIDTH-1];
          // Most negative input wraps to itself, which reads as 2^(WIDTH-1) unsigned.
          mag_d     = bus.din[WIDTH-1] ? (~bus.din + WIDTH'(1)) : bus.din;
          scratch_d = '0;
          count_d   = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        {scratch_d, mag_d} = {adjusted, mag_q} << 1;
        count_d            = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        bcd_d   = scratch_q;
        neg_d   = sign_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      done_q    <= done_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.neg  = neg_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Scoreboard bench for signed_bcd_converter: directed cases, handshake timing and a full sweep.
module tb_signed_bcd_converter;

  localparam int W = 8;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  logic [12:0] exp_q[$];
  logic [12:0] prev;
  logic [12:0] popped;

  signed_bcd_converter_if #(.WIDTH(W), .DIGITS(D)) bus ();

  signed_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] model(input logic [7:0] d);
    int v;
    int m;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    return {(v < 0) ? 1'b1 : 1'b0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      done_cnt++;
      check_eq("busy_with_done", bus.busy, 0);
      check_eq("expected_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        popped = exp_q.pop_front();
        check_eq("result", {bus.neg, bus.bcd}, popped);
      end
    end
  end

  task automatic run_conv(input logic [7:0] d);
    int g;
    int lat;
    int dc0;
    g = 0;
    while (bus.busy && g < 40) begin
      tick();
      g++;
    end
    check_eq("idle_before_start", bus.busy, 0);
    bus.start = 1'b1;
    bus.din   = d;
    exp_q.push_back(model(d));
    tick();
    bus.start = 1'b0;
    check_eq("busy_after_accept", bus.busy, 1);
    check_eq("hold_prev", {bus.neg, bus.bcd}, prev);
    dc0 = done_cnt;
    lat = 0;
    while (!bus.done && lat < 20) begin
      bus.din = 8'($urandom);
      tick();
      lat++;
    end
    check_eq("latency", lat, 9);
    tick();
    check_eq("done_one_cycle", bus.done, 0);
    check_eq("one_done", done_cnt - dc0, 1);
    prev = model(d);
  endtask

  initial begin
    int lat;
    int dc0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.din   = '0;
    prev      = '0;
    repeat (3) tick();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_result", {bus.neg, bus.bcd}, 0);
    reset = 1'b0;
    tick();

    run_conv(8'h00);
    run_conv(8'h7F);
    run_conv(8'hF9);
    run_conv(8'h80);

    // Restart attempt while busy must be dropped.
    bus.start = 1'b1;
    bus.din   = 8'h9C;
    exp_q.push_back(model(8'h9C));
    tick();
    bus.start = 1'b0;
    dc0 = done_cnt;
    lat = 0;
    repeat (2) begin
      tick();
      lat++;
    end
    bus.start = 1'b1;
    bus.din   = 8'h05;
    tick();
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("restart_latency", lat, 9);
    repeat (12) tick();
    check_eq("restart_one_done", done_cnt - dc0, 1);
    prev = model(8'h9C);

    // Reset mid-conversion aborts without a done pulse.
    bus.start = 1'b1;
    bus.din   = 8'h40;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    dc0   = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_done", bus.done, 0);
    check_eq("abort_result", {bus.neg, bus.bcd}, 0);
    repeat (12) tick();
    check_eq("abort_no_done", done_cnt - dc0, 0);
    prev = '0;
    run_conv(8'h0A);

    // Start held high: back-to-back accepts on the done cycle.
    bus.start = 1'b1;
    bus.din   = 8'h01;
    exp_q.push_back(model(8'h01));
    exp_q.push_back(model(8'hFF));
    tick();
    bus.din = 8'hFF;
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("held_first_latency", lat, 9);
    tick();
    bus.start = 1'b0;
    check_eq("held_reaccept_busy", bus.busy, 1);
    lat = 1;
    while (!bus.done && lat < 30) begin
      tick();
      lat++;
    end
    check_eq("held_done_period", lat, 10);
    tick();
    prev = model(8'hFF);

    for (int i = 0; i < 256; i++) begin
      run_conv(8'(i));
    end

    repeat (4) tick();
    check_eq("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
